// File: rtl/dbg_uart_pkg.sv
// Shared types and defaults for the debug UART transceiver.
package dbg_uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_t;

  localparam int DBG_UART_CLKS_PER_BIT_DEF = 87;
  localparam int DBG_UART_DATA_W           = 8;

endpackage

// File: rtl/dbg_uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module dbg_uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dbg_uart_core.sv
// Debug UART core: independent 8N1 transmitter and receiver, LSB first,
// one bit every CLKS_PER_BIT clocks.
module dbg_uart_core
  import dbg_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DBG_UART_CLKS_PER_BIT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_tx_dv,
  input  logic [DBG_UART_DATA_W-1:0] in_tx_byte,
  output logic                       w_tx_active,
  output logic                       out_tx_serial,
  output logic                       w_tx_done,
  input  logic                       in_rx_serial,
  output logic                       out_rx_dv,
  output logic [DBG_UART_DATA_W-1:0] out_rx_byte
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);

  // ---------------- TX ----------------
  uart_state_t                tx_state, tx_state_n;
  logic [CNT_W-1:0]           tx_cnt, tx_cnt_n;
  logic [2:0]                 tx_bit, tx_bit_n;
  logic [DBG_UART_DATA_W-1:0] tx_data, tx_data_n;
  logic                       tx_serial_n, tx_active_n, tx_done_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state      <= IDLE;
      tx_cnt        <= '0;
      tx_bit        <= '0;
      tx_data       <= '0;
      out_tx_serial <= 1'b1;
      w_tx_active   <= 1'b0;
      w_tx_done     <= 1'b0;
    end else begin
      tx_state      <= tx_state_n;
      tx_cnt        <= tx_cnt_n;
      tx_bit        <= tx_bit_n;
      tx_data       <= tx_data_n;
      out_tx_serial <= tx_serial_n;
      w_tx_active   <= tx_active_n;
      w_tx_done     <= tx_done_n;
    end
  end

  // Line level is registered one state ahead so each bit starts on its state's first cycle.
  always_comb begin
    tx_state_n  = tx_state;
    tx_cnt_n    = tx_cnt;
    tx_bit_n    = tx_bit;
    tx_data_n   = tx_data;
    tx_serial_n = out_tx_serial;
    tx_active_n = w_tx_active;
    tx_done_n   = w_tx_done;
    case (tx_state)
      IDLE: begin
        tx_serial_n = 1'b1;
        tx_cnt_n    = '0;
        tx_bit_n    = '0;
        if (in_tx_dv) begin
          tx_data_n   = in_tx_byte;
          tx_active_n = 1'b1;
          tx_serial_n = 1'b0;
          tx_state_n  = START;
        end
      end
      START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n    = '0;
          tx_serial_n = tx_data[0];
          tx_state_n  = DATA;
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_serial_n = 1'b1;
            tx_state_n  = STOP;
          end else begin
            tx_bit_n    = tx_bit + 3'd1;
            tx_serial_n = tx_data[tx_bit + 3'd1];
          end
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n    = '0;
          tx_done_n   = 1'b1;
          tx_active_n = 1'b0;
          tx_state_n  = CLEANUP;
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      CLEANUP: begin
        tx_done_n  = 1'b0;
        tx_state_n = IDLE;
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // ---------------- RX ----------------
  logic rx_sync;

  dbg_uart_sync2 #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (in_rx_serial),
    .q   (rx_sync)
  );

  uart_state_t                rx_state, rx_state_n;
  logic [CNT_W-1:0]           rx_cnt, rx_cnt_n;
  logic [2:0]                 rx_bit, rx_bit_n;
  logic [DBG_UART_DATA_W-1:0] rx_shift, rx_shift_n;
  logic [DBG_UART_DATA_W-1:0] rx_byte_n;
  logic                       rx_dv_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state    <= IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      out_rx_byte <= '0;
      out_rx_dv   <= 1'b0;
    end else begin
      rx_state    <= rx_state_n;
      rx_cnt      <= rx_cnt_n;
      rx_bit      <= rx_bit_n;
      rx_shift    <= rx_shift_n;
      out_rx_byte <= rx_byte_n;
      out_rx_dv   <= rx_dv_n;
    end
  end

  // After the half-bit wait in START, every later sample lands at a bit centre.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_byte_n  = out_rx_byte;
    rx_dv_n    = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        if (!rx_sync) rx_state_n = START;
      end
      START: begin
        if (rx_cnt == CNT_MID) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_sync ? IDLE : DATA;
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n           = '0;
          rx_shift_n[rx_bit] = rx_sync;
          if (rx_bit == 3'd7) rx_state_n = STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = CLEANUP;
          if (rx_sync) begin
            rx_byte_n = rx_shift;
            rx_dv_n   = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      CLEANUP: rx_state_n = IDLE;
      default: rx_state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dbg_uart_core.sv
// Scoreboard bench for dbg_uart_core: drivers queue expected frames/bytes,
// independent monitors decode the DUT outputs and compare.
`timescale 1ns/1ps
module tb_dbg_uart_core;

  localparam int CPB   = 87;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_tx_dv = 1'b0;
  logic [7:0] in_tx_byte = 8'h00;
  logic       w_tx_active, out_tx_serial, w_tx_done;
  logic       rx_drv = 1'b1;
  logic       loopback = 1'b0;
  logic       in_rx_serial;
  logic       out_rx_dv;
  logic [7:0] out_rx_byte;

  assign in_rx_serial = loopback ? out_tx_serial : rx_drv;

  always #50 clk = ~clk;

  dbg_uart_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_tx_dv      (in_tx_dv),
    .in_tx_byte    (in_tx_byte),
    .w_tx_active   (w_tx_active),
    .out_tx_serial (out_tx_serial),
    .w_tx_done     (w_tx_done),
    .in_rx_serial  (in_rx_serial),
    .out_rx_dv     (out_rx_dv),
    .out_rx_byte   (out_rx_byte)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  b;
    int unsigned start;
  } tx_exp_t;

  tx_exp_t     txq[$];
  logic [7:0]  rxq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned tx_next_free = 0;
  logic [7:0]  last_rx_exp = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a strobe starts a frame only if the transmitter has been idle
  // (a full frame plus the cleanup cycle elapsed since the previous accepted start).
  task automatic tx_send(input logic [7:0] b);
    @(negedge clk);
    in_tx_byte = b;
    in_tx_dv   = 1'b1;
    if (rst && cyc >= tx_next_free) begin
      txq.push_back('{b, cyc + 1});
      tx_next_free = cyc + 1 + FRAME + 1;
    end
    @(negedge clk);
    in_tx_dv   = 1'b0;
    in_tx_byte = 8'($urandom);
  endtask

  task automatic rx_send(input logic [7:0] b, input int start_len, input int bit_len,
                         input logic stop_val);
    if (stop_val) begin
      rxq.push_back(b);
      last_rx_exp = b;
    end
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (start_len) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (bit_len) @(negedge clk);
    end
    rx_drv = stop_val;
    repeat (bit_len) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  // TX monitor: expects the frame {stop=1, byte, start=0} bit by bit, each CPB cycles.
  logic        tx_in_frame = 1'b0;
  logic        tx_done_wait = 1'b0;
  logic        tx_bad = 1'b0;
  int unsigned tx_pos = 0;
  int unsigned tx_idx;
  logic        tx_expbit;
  tx_exp_t     tx_cur;

  always @(negedge clk) begin
    if (!rst) begin
      tx_in_frame  = 1'b0;
      tx_done_wait = 1'b0;
    end else begin
      if (!tx_in_frame && !tx_done_wait && out_tx_serial === 1'b0) begin
        if (txq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected_frame: line low at cycle %0d with no frame expected", cyc);
          tx_cur = '{8'h00, cyc};
        end else begin
          tx_cur = txq.pop_front();
          check("tx_start_cycle", cyc, tx_cur.start);
        end
        tx_in_frame = 1'b1;
        tx_pos      = 0;
        tx_bad      = 1'b0;
      end
      if (tx_in_frame) begin
        tx_idx = tx_pos / CPB;
        if (tx_idx == 0)      tx_expbit = 1'b0;
        else if (tx_idx == 9) tx_expbit = 1'b1;
        else                  tx_expbit = tx_cur.b[tx_idx - 1];
        if (out_tx_serial !== tx_expbit || w_tx_active !== 1'b1 || w_tx_done !== 1'b0)
          tx_bad = 1'b1;
        tx_pos++;
        if (tx_pos == FRAME) begin
          checks++;
          if (tx_bad) begin
            errors++;
            $display("FAIL tx_frame: byte %0h frame shape wrong, got bad=1 required bad=0", tx_cur.b);
          end
          tx_in_frame  = 1'b0;
          tx_done_wait = 1'b1;
        end
      end else if (tx_done_wait) begin
        check("tx_done_pulse", {29'd0, w_tx_done, w_tx_active, out_tx_serial}, 32'h5);
        tx_done_wait = 1'b0;
      end else begin
        check("tx_idle", {30'd0, w_tx_done, w_tx_active}, 32'h0);
      end
    end
  end

  // RX monitor: every dv pulse must match the next queued byte.
  logic [7:0] rx_e;
  always @(negedge clk) begin
    if (rst && out_rx_dv === 1'b1) begin
      if (rxq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected_dv: got byte %0h required no dv", out_rx_byte);
      end else begin
        rx_e = rxq.pop_front();
        check("rx_byte", {24'd0, out_rx_byte}, {24'd0, rx_e});
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check(name, {27'd0, out_tx_serial, w_tx_active, w_tx_done, out_rx_dv, 1'b0} | {24'd0, out_rx_byte} << 8,
          32'h10);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b1;

    // 1: single TX frame
    tx_send(8'hAB);
    repeat (FRAME + 20) @(negedge clk);

    // 2: RX with lengthened start bit and shortened data bits
    rx_send(8'h3F, 96, 86, 1'b1);
    repeat (50) @(negedge clk);
    check("rx_hold_3f", {24'd0, out_rx_byte}, {24'd0, last_rx_exp});

    // 3: glitch on RX line
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check("rx_hold_glitch", {24'd0, out_rx_byte}, {24'd0, last_rx_exp});

    // 4: framing error
    rx_send(8'h55, CPB, CPB, 1'b0);
    repeat (150) @(negedge clk);
    check("rx_hold_framing", {24'd0, out_rx_byte}, {24'd0, last_rx_exp});

    // 5: strobe while busy is dropped
    fork
      tx_send(8'hAB);
      begin
        repeat (300) @(negedge clk);
        tx_send(8'h12);
      end
    join
    repeat (FRAME) @(negedge clk);

    // Randomised full-duplex traffic; TX gaps straddle the idle boundary.
    fork
      for (int i = 0; i < 8; i++) begin
        tx_send(8'($urandom));
        repeat ($urandom_range(FRAME - 4, FRAME + 4)) @(negedge clk);
      end
      for (int j = 0; j < 8; j++) begin
        rx_send(8'($urandom), int'($urandom_range(80, 100)), int'($urandom_range(84, 90)), 1'b1);
        repeat ($urandom_range(10, 60)) @(negedge clk);
      end
    join
    repeat (FRAME + 20) @(negedge clk);
    check("rx_hold_random", {24'd0, out_rx_byte}, {24'd0, last_rx_exp});

    // 6: reset with TX in data bit 3 and RX in data bit 4
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (85) @(negedge clk);
    tx_send(8'h5A);
    repeat (470 - 88) @(negedge clk);
    rst    = 1'b0;
    rx_drv = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_midframe");
    tx_next_free = 0;
    last_rx_exp  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    loopback = 1'b1;
    rxq.push_back(8'hC3);
    last_rx_exp = 8'hC3;
    tx_send(8'hC3);
    repeat (FRAME + 60) @(negedge clk);
    loopback = 1'b0;
    check("rx_hold_loop", {24'd0, out_rx_byte}, {24'd0, last_rx_exp});

    check("txq_drained", txq.size(), 32'd0);
    check("rxq_drained", rxq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
